// File: rtl/dsp_pkg.sv
// Shared definitions for the multichannel MAC slice: OPMODE field positions,
// post-adder operand selects and the saturation clamp helper.
package dsp_pkg;

  // OPMODE bit positions; XSEL and ZSEL are the LSBs of 2-bit fields.
  localparam int unsigned XSEL    = 0;
  localparam int unsigned ZSEL    = 2;
  localparam int unsigned PREEN   = 4;
  localparam int unsigned CINBIT  = 5;
  localparam int unsigned PRESUB  = 6;
  localparam int unsigned POSTSUB = 7;

  typedef enum logic [1:0] {
    XZero = 2'd0,
    XMult = 2'd1,
    XAcc  = 2'd2,
    XC    = 2'd3
  } xsel_e;

  typedef enum logic [1:0] {
    ZZero = 2'd0,
    ZPcin = 2'd1,
    ZAcc  = 2'd2,
    ZC    = 2'd3
  } zsel_e;

  // Post-adder controls carried from S2 to S4.
  typedef struct packed {
    logic  post_sub;
    logic  cin;
    zsel_e zsel;
    xsel_e xsel;
  } post_mode_t;

  localparam int unsigned SatMaxW = 128;

  // Signed clamp for a width-bit result; caller truncates to width.
  function automatic logic [SatMaxW-1:0] sat_clamp(input logic neg, input int unsigned width);
    logic [SatMaxW-1:0] max_v;
    max_v = (SatMaxW'(1) << (width - 1)) - SatMaxW'(1);
    return neg ? ~max_v : max_v;
  endfunction

endpackage

// File: rtl/dsp_acc_bank.sv
// Bank of per-channel accumulators with one combinational read port and one write port.
// Addresses at or above NumCh read as zero and are never written.
module dsp_acc_bank #(
  parameter int unsigned NumCh = 4,
  parameter int unsigned Width = 48,
  parameter int unsigned AddrW = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i
);

  logic [Width-1:0] acc_q [NumCh];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumCh); i++) acc_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < int'(NumCh); i++) begin
        if (wr_addr_i == AddrW'(i)) acc_q[i] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < int'(NumCh); i++) begin
      if (rd_addr_i == AddrW'(i)) rd_data_o = acc_q[i];
    end
  end

endmodule

// File: rtl/dsp_mac_multich.sv
// Four-stage pre-add / multiply / post-add slice with NUM_CH interleaved accumulators.
// Define DSP_MAC_SATURATE_EN to clamp signed overflow of the post-adder result.
module dsp_mac_multich
  import dsp_pkg::*;
#(
  parameter int unsigned A_WIDTH = 18,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned C_WIDTH = 48,
  parameter int unsigned P_WIDTH = 48,
  parameter int unsigned NUM_CH  = 4,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       CE,
  input  logic                       IN_VALID,
  input  logic [CH_W-1:0]            CH_IN,
  input  logic [7:0]                 OPMODE,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  input  logic [B_WIDTH-1:0]         D,
  input  logic [C_WIDTH-1:0]         C,
  input  logic [C_WIDTH-1:0]         PCIN,
  output logic                       OUT_VALID,
  output logic [CH_W-1:0]            CH_OUT,
  output logic [P_WIDTH-1:0]         P,
  output logic [P_WIDTH-1:0]         PCOUT,
  output logic [A_WIDTH+B_WIDTH:0]   M,
  output logic                       CARRYOUT,
  output logic                       OVERFLOW
);

  localparam int unsigned PreW = B_WIDTH + 1;
  localparam int unsigned MW   = A_WIDTH + B_WIDTH + 1;
  localparam int unsigned RW   = P_WIDTH + 1;

  // S1
  logic                 v1;
  logic [CH_W-1:0]      ch1;
  logic [7:0]           op1;
  logic [A_WIDTH-1:0]   a1;
  logic [B_WIDTH-1:0]   b1, d1;
  logic [C_WIDTH-1:0]   c1, pcin1;
  // S2
  logic                 v2;
  logic [CH_W-1:0]      ch2;
  post_mode_t           pm2, pm_d;
  logic [A_WIDTH-1:0]   a2;
  logic [PreW-1:0]      pre2, pre_d;
  logic [C_WIDTH-1:0]   c2, pcin2;
  // S3
  logic                 v3;
  logic [CH_W-1:0]      ch3;
  post_mode_t           pm3;
  logic [MW-1:0]        m3, m_d;
  logic [C_WIDTH-1:0]   c3, pcin3;
  // S4
  logic                 outv_q, carry_q, ovf_q;
  logic [CH_W-1:0]      chout_q;
  logic [P_WIDTH-1:0]   p_q;

  logic [P_WIDTH-1:0]   acc_rd, x_op, z_op, m_ext, c_ext, pcin_ext, res_d;
  logic [RW-1:0]        r_full, cin_ext;
  logic                 ovf_d;
  logic                 acc_we;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v1 <= 1'b0; ch1 <= '0; op1 <= '0; a1 <= '0; b1 <= '0; d1 <= '0; c1 <= '0; pcin1 <= '0;
    end else if (CE) begin
      v1 <= IN_VALID;
      if (IN_VALID) begin
        ch1 <= CH_IN; op1 <= OPMODE; a1 <= A; b1 <= B; d1 <= D; c1 <= C; pcin1 <= PCIN;
      end
    end
  end

  // Pre-adder at full B_WIDTH+1 precision.
  always_comb begin
    pre_d = {b1[B_WIDTH-1], b1};
    if (op1[PREEN]) begin
      if (op1[PRESUB]) pre_d = {d1[B_WIDTH-1], d1} - {b1[B_WIDTH-1], b1};
      else             pre_d = {d1[B_WIDTH-1], d1} + {b1[B_WIDTH-1], b1};
    end
    pm_d.post_sub = op1[POSTSUB];
    pm_d.cin      = op1[CINBIT];
    pm_d.zsel     = zsel_e'(op1[ZSEL +: 2]);
    pm_d.xsel     = xsel_e'(op1[XSEL +: 2]);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v2 <= 1'b0; ch2 <= '0; pm2 <= '0; a2 <= '0; pre2 <= '0; c2 <= '0; pcin2 <= '0;
    end else if (CE) begin
      v2 <= v1;
      if (v1) begin
        ch2 <= ch1; pm2 <= pm_d; a2 <= a1; pre2 <= pre_d; c2 <= c1; pcin2 <= pcin1;
      end
    end
  end

  assign m_d = MW'(signed'(a2)) * MW'(signed'(pre2));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v3 <= 1'b0; ch3 <= '0; pm3 <= '0; m3 <= '0; c3 <= '0; pcin3 <= '0;
    end else if (CE) begin
      v3 <= v2;
      if (v2) begin
        ch3 <= ch2; pm3 <= pm2; m3 <= m_d; c3 <= c2; pcin3 <= pcin2;
      end
    end
  end

  assign acc_we = CE & v3;

  dsp_acc_bank #(
    .NumCh (NUM_CH),
    .Width (P_WIDTH),
    .AddrW (CH_W)
  ) u_acc_bank (
    .clk_i     (CLK),
    .rst_ni    (RSTN),
    .rd_addr_i (ch3),
    .rd_data_o (acc_rd),
    .we_i      (acc_we),
    .wr_addr_i (ch3),
    .wr_data_i (res_d)
  );

  assign m_ext    = P_WIDTH'(signed'(m3));
  assign c_ext    = P_WIDTH'(signed'(c3));
  assign pcin_ext = P_WIDTH'(signed'(pcin3));
  assign cin_ext  = RW'(pm3.cin);

  always_comb begin
    unique case (pm3.xsel)
      XZero:   x_op = '0;
      XMult:   x_op = m_ext;
      XAcc:    x_op = acc_rd;
      XC:      x_op = c_ext;
      default: x_op = '0;
    endcase
    unique case (pm3.zsel)
      ZZero:   z_op = '0;
      ZPcin:   z_op = pcin_ext;
      ZAcc:    z_op = acc_rd;
      ZC:      z_op = c_ext;
      default: z_op = '0;
    endcase
  end

  // Zero-extended arithmetic puts carry/borrow in the top bit.
`ifdef DSP_MAC_SATURATE_EN
  logic [RW-1:0] r_sgn;
`endif

  always_comb begin
    if (pm3.post_sub) r_full = {1'b0, z_op} - {1'b0, x_op} - cin_ext;
    else              r_full = {1'b0, z_op} + {1'b0, x_op} + cin_ext;
`ifdef DSP_MAC_SATURATE_EN
    if (pm3.post_sub) r_sgn = {z_op[P_WIDTH-1], z_op} - {x_op[P_WIDTH-1], x_op} - cin_ext;
    else              r_sgn = {z_op[P_WIDTH-1], z_op} + {x_op[P_WIDTH-1], x_op} + cin_ext;
    ovf_d = r_sgn[P_WIDTH] ^ r_sgn[P_WIDTH-1];
    res_d = ovf_d ? P_WIDTH'(sat_clamp(r_sgn[P_WIDTH], P_WIDTH)) : r_full[P_WIDTH-1:0];
`else
    ovf_d = 1'b0;
    res_d = r_full[P_WIDTH-1:0];
`endif
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      outv_q <= 1'b0; chout_q <= '0; p_q <= '0; carry_q <= 1'b0; ovf_q <= 1'b0;
    end else if (CE) begin
      outv_q <= v3;
      ovf_q  <= v3 & ovf_d;
      if (v3) begin
        chout_q <= ch3; p_q <= res_d; carry_q <= r_full[P_WIDTH];
      end
    end
  end

  assign OUT_VALID = outv_q;
  assign CH_OUT    = chout_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign M         = m3;
  assign CARRYOUT  = carry_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_dsp_mac_multich.sv
// Directed-vector bench for dsp_mac_multich (NUM_CH=3 so channel 3 is out of range).
module tb_dsp_mac_multich;

  logic        CLK = 1'b0;
  logic        RSTN, CE, IN_VALID;
  logic [1:0]  CH_IN;
  logic [7:0]  OPMODE;
  logic [17:0] A, B, D;
  logic [47:0] C, PCIN;
  logic        OUT_VALID, CARRYOUT, OVERFLOW;
  logic [1:0]  CH_OUT;
  logic [47:0] P, PCOUT;
  logic [36:0] M;

  int n_tests = 0;
  int n_fail  = 0;

  dsp_mac_multich #(
    .A_WIDTH (18),
    .B_WIDTH (18),
    .C_WIDTH (48),
    .P_WIDTH (48),
    .NUM_CH  (3)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .CE        (CE),
    .IN_VALID  (IN_VALID),
    .CH_IN     (CH_IN),
    .OPMODE    (OPMODE),
    .A         (A),
    .B         (B),
    .D         (D),
    .C         (C),
    .PCIN      (PCIN),
    .OUT_VALID (OUT_VALID),
    .CH_OUT    (CH_OUT),
    .P         (P),
    .PCOUT     (PCOUT),
    .M         (M),
    .CARRYOUT  (CARRYOUT),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] op,
                       input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                       input logic [47:0] c, input logic [47:0] pcin);
    IN_VALID = v; CH_IN = ch; OPMODE = op; A = a; B = b; D = d; C = c; PCIN = pcin;
  endtask

  task automatic idle();
    IN_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({OUT_VALID, CH_OUT, P, PCOUT, M, CARRYOUT, OVERFLOW} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ch=%0d p=%h m=%h co=%b of=%b want all 0",
               OUT_VALID, CH_OUT, P, M, CARRYOUT, OVERFLOW);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 2'd0, 8'h01, 18'd3, 18'd5, 18'd0, 48'd0, 48'd0);
    tick(); idle(); tick(); tick();
    n_tests++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency3: got ov=%b want 0", OUT_VALID);
    end
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b1 || P !== 48'd15 || PCOUT !== 48'd15 || M !== 37'd15 || CH_OUT !== 2'd0)
    begin
      n_fail++;
      $display("FAIL basic_mul: got ov=%b p=%0d pc=%0d m=%0d ch=%0d want 1 15 15 15 0",
               OUT_VALID, P, PCOUT, M, CH_OUT);
    end
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b0 || P !== 48'd15) begin
      n_fail++; $display("FAIL basic_hold: got ov=%b p=%0d want 0 15", OUT_VALID, P);
    end
  endtask

  task automatic test_preadder();
    drive(1'b1, 2'd1, 8'h51, -18'sd2, 18'd4, 18'd10, 48'd0, 48'd0);
    tick(); idle(); tick(); tick(); tick();
    n_tests++;
    if (OUT_VALID !== 1'b1 || P !== -48'sd12 || M !== -37'sd12 || CH_OUT !== 2'd1) begin
      n_fail++;
      $display("FAIL pre_sub: got ov=%b p=%0d m=%0d ch=%0d want 1 -12 -12 1",
               OUT_VALID, $signed(P), $signed(M), CH_OUT);
    end
    drive(1'b1, 2'd2, 8'h11, 18'd3, 18'd4, 18'd10, 48'd0, 48'd0);
    tick(); idle(); tick(); tick(); tick();
    n_tests++;
    if (OUT_VALID !== 1'b1 || P !== 48'd42 || M !== 37'd42 || CH_OUT !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_add: got ov=%b p=%0d m=%0d ch=%0d want 1 42 42 2",
               OUT_VALID, $signed(P), $signed(M), CH_OUT);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    drive(1'b1, 2'd0, 8'h01, 18'd7, 18'd1, 18'd0, 48'd0, 48'd0);
    tick(); idle(); tick();
    RSTN = 1'b0;
    #1;
    n_tests++;
    if ({OUT_VALID, CH_OUT, P, PCOUT, M, CARRYOUT, OVERFLOW} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got ov=%b ch=%0d p=%0d m=%0d want all 0",
               OUT_VALID, CH_OUT, P, M);
    end
    @(posedge CLK); #1;
    RSTN = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (OUT_VALID !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_drop: got %0d valid cycles want 0", bad);
    end
    drive(1'b1, 2'd0, 8'h01, 18'd1, 18'd9, 18'd0, 48'd0, 48'd0);
    tick(); idle();
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (OUT_VALID !== 1'b0) bad++;
    end
    tick();
    n_tests++;
    if (bad != 0 || OUT_VALID !== 1'b1 || P !== 48'd9) begin
      n_fail++;
      $display("FAIL reset_resume: got early=%0d ov=%b p=%0d want 0 1 9", bad, OUT_VALID, P);
    end
  endtask

  task automatic test_interleave();
    logic [47:0] exp_p;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(1'b1, 2'(i % 2), 8'h09, 18'd1, (i % 2) ? 18'd100 : 18'd1, 18'd0,
                       48'd0, 48'd0);
      else idle();
      tick();
      if (i >= 3) begin
        exp_p = 48'(((i - 3) % 2 ? 100 : 1) * ((i - 3) / 2 + 1));
        n_tests++;
        if (OUT_VALID !== 1'b1 || CH_OUT !== 2'((i - 3) % 2) || P !== exp_p) begin
          n_fail++;
          $display("FAIL interleave_%0d: got ov=%b ch=%0d p=%0d want 1 %0d %0d",
                   i - 3, OUT_VALID, CH_OUT, P, (i - 3) % 2, exp_p);
        end
      end
    end
    idle();
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b0 || P !== 48'd400) begin
      n_fail++; $display("FAIL interleave_end: got ov=%b p=%0d want 0 400", OUT_VALID, P);
    end
  endtask

  task automatic test_ce_stall();
    int bad;
    drive(1'b1, 2'd0, 8'h01, 18'd2, 18'd3, 18'd0, 48'd0, 48'd0);
    tick();
    drive(1'b1, 2'd0, 8'h01, 18'd4, 18'd5, 18'd0, 48'd0, 48'd0);
    tick();
    CE = 1'b0;
    drive(1'b1, 2'd0, 8'h01, 18'd9, 18'd9, 18'd0, 48'd0, 48'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (OUT_VALID !== 1'b0 || P !== 48'd400) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ce_frozen: got %0d changed cycles want 0", bad);
    end
    idle();
    CE = 1'b1;
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL ce_early: got ov=%b want 0 at cycle 6", OUT_VALID);
    end
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b1 || P !== 48'd6) begin
      n_fail++; $display("FAIL ce_lat7: got ov=%b p=%0d want 1 6", OUT_VALID, P);
    end
    CE = 1'b0;
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b1 || P !== 48'd6) begin
      n_fail++; $display("FAIL ce_hold_out: got ov=%b p=%0d want 1 6", OUT_VALID, P);
    end
    CE = 1'b1;
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b1 || P !== 48'd20) begin
      n_fail++; $display("FAIL ce_second: got ov=%b p=%0d want 1 20", OUT_VALID, P);
    end
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b0 || P !== 48'd20) begin
      n_fail++; $display("FAIL ce_nodup: got ov=%b p=%0d want 0 20", OUT_VALID, P);
    end
  endtask

  task automatic test_post_adder();
    logic [7:0]  op_t [4];
    logic [47:0] c_t [4];
    logic [47:0] exp_p [4];
    logic        exp_c [4];
    op_t[0] = 8'h07; c_t[0] = 48'd7;           exp_p[0] = 48'd12;  exp_c[0] = 1'b0;
    op_t[1] = 8'h87; c_t[1] = 48'd7;           exp_p[1] = -48'sd2; exp_c[1] = 1'b1;
    op_t[2] = 8'hA7; c_t[2] = 48'd7;           exp_p[2] = -48'sd3; exp_c[2] = 1'b1;
    op_t[3] = 8'h0F; c_t[3] = 48'hFFFFFFFFFFFF; exp_p[3] = -48'sd2; exp_c[3] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 2'd1, op_t[i], 18'd0, 18'd0, 18'd0, c_t[i], 48'd5);
      else idle();
      tick();
      if (i >= 3) begin
        n_tests++;
        if (OUT_VALID !== 1'b1 || P !== exp_p[i-3] || CARRYOUT !== exp_c[i-3] ||
            OVERFLOW !== 1'b0) begin
          n_fail++;
          $display("FAIL post_add_%0d: got ov=%b p=%h co=%b of=%b want 1 %h %b 0",
                   i - 3, OUT_VALID, P, CARRYOUT, OVERFLOW, exp_p[i-3], exp_c[i-3]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [47:0] exp_p [3];
    logic        exp_o [3];
    exp_p[0] = 48'h7FFF_FFFF_FFFF; exp_o[0] = 1'b0;
`ifdef DSP_MAC_SATURATE_EN
    exp_p[1] = 48'h7FFF_FFFF_FFFF; exp_o[1] = 1'b1;
    exp_p[2] = 48'h7FFF_FFFF_FFFF; exp_o[2] = 1'b1;
`else
    exp_p[1] = 48'h8000_0000_0000; exp_o[1] = 1'b0;
    exp_p[2] = 48'h8000_0000_0001; exp_o[2] = 1'b0;
`endif
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b1, 2'd0, 8'h03, 18'd0, 18'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 48'd0);
      else if (i < 3) drive(1'b1, 2'd0, 8'h09, 18'd1, 18'd1, 18'd0, 48'd0, 48'd0);
      else idle();
      tick();
      if (i >= 3) begin
        n_tests++;
        if (OUT_VALID !== 1'b1 || P !== exp_p[i-3] || OVERFLOW !== exp_o[i-3] ||
            CARRYOUT !== 1'b0) begin
          n_fail++;
          $display("FAIL overflow_%0d: got ov=%b p=%h of=%b co=%b want 1 %h %b 0",
                   i - 3, OUT_VALID, P, OVERFLOW, CARRYOUT, exp_p[i-3], exp_o[i-3]);
        end
      end
    end
    tick();
    n_tests++;
    if (OUT_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
      n_fail++; $display("FAIL overflow_clear: got ov=%b of=%b want 0 0", OUT_VALID, OVERFLOW);
    end
  endtask

  task automatic test_oor_channel();
    for (int i = 0; i < 5; i++) begin
      if (i < 2) drive(1'b1, 2'd3, 8'h09, 18'd2, 18'd3, 18'd0, 48'd0, 48'd0);
      else idle();
      tick();
      if (i >= 3) begin
        n_tests++;
        if (OUT_VALID !== 1'b1 || CH_OUT !== 2'd3 || P !== 48'd6) begin
          n_fail++;
          $display("FAIL oor_ch_%0d: got ov=%b ch=%0d p=%0d want 1 3 6",
                   i - 3, OUT_VALID, CH_OUT, P);
        end
      end
    end
  endtask

  initial begin
    RSTN = 1'b0;
    CE   = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0);
    #2;
    test_reset();
    tick();
    RSTN = 1'b1;
    test_basic();
    test_preadder();
    test_reset_mid();
    test_interleave();
    test_ce_stall();
    test_post_adder();
    test_overflow();
    test_oor_channel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
